// File: rtl/cic_interpolator.sv
// M-stage CIC interpolator: input-rate combs, zero-stuffing by R = 2^LOG2_R, ce-paced integrators, output scaled by 1/R^(M-1).
// Optional output clamping when CIC_INTERP_SAT_EN is defined; otherwise the output slice wraps.
module cic_interpolator #(
    parameter int M         = 5,
    parameter int LOG2_R    = 5,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [IN_WIDTH-1:0]  d_in,
    input  logic                 d_in_valid,
    output logic                 d_in_ready,
    output logic [OUT_WIDTH-1:0] d_out,
    output logic                 d_out_valid,
    output logic                 underrun
);
    localparam int W     = IN_WIDTH + M * LOG2_R;
    localparam int SHIFT = (M - 1) * LOG2_R;

    logic [W-1:0]           hold_r;
    logic                   hold_valid_r;
    logic [LOG2_R-1:0]      phase_r;
    logic [W-1:0]           comb_z_r [M];
    logic [W-1:0]           u_r;
    logic [W-1:0]           integ_r [M];
    logic [OUT_WIDTH-1:0]   d_out_r;
    logic                   d_out_valid_r;
    logic                   underrun_r;

    logic                   slot_s;
    logic                   pop_s;
    logic                   push_s;
    logic [M-1:0][W-1:0]    comb_x_s;
    logic [W-1:0]           comb_out_s;
    logic [OUT_WIDTH-1:0]   out_next_s;

`ifdef CIC_INTERP_SAT_EN
    function automatic logic [OUT_WIDTH-1:0] norm_out(input logic [W-1:0] acc);
        logic signed [W-1:0] shifted;
        logic signed [W-1:0] hi;
        logic signed [W-1:0] lo;
        shifted = $signed(acc) >>> SHIFT;
        hi      = $signed({{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
        lo      = ~hi;
        if (shifted > hi) begin
            norm_out = hi[OUT_WIDTH-1:0];
        end else if (shifted < lo) begin
            norm_out = lo[OUT_WIDTH-1:0];
        end else begin
            norm_out = shifted[OUT_WIDTH-1:0];
        end
    endfunction
`else
    function automatic logic [OUT_WIDTH-1:0] norm_out(input logic [W-1:0] acc);
        norm_out = acc[SHIFT +: OUT_WIDTH];
    endfunction
`endif

    // Slot decode and single-entry handshake
    always_comb begin
        slot_s     = ce & (phase_r == {LOG2_R{1'b0}});
        pop_s      = slot_s & hold_valid_r;
        d_in_ready = ~hold_valid_r | pop_s;
        push_s     = d_in_valid & d_in_ready;
    end

    // Comb cascade; an empty holding register injects zero
    always_comb begin
        logic [W-1:0] acc_v;
        comb_x_s = {(M*W){1'b0}};
        acc_v    = hold_valid_r ? hold_r : {W{1'b0}};
        for (int k = 0; k < M; k++) begin
            comb_x_s[k] = acc_v;
            acc_v       = acc_v - comb_z_r[k];
        end
        comb_out_s = acc_v;
    end

    // Divide by the DC gain R^(M-1) before presenting the sample
    always_comb begin
        out_next_s = norm_out(integ_r[M-1]);
    end

    // Input holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r       <= {W{1'b0}};
            hold_valid_r <= 1'b0;
        end else if (push_s) begin
            hold_r       <= {{(W-IN_WIDTH){d_in[IN_WIDTH-1]}}, d_in};
            hold_valid_r <= 1'b1;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end
    end

    // ce-paced datapath: phase, comb delays, zero-stuffing, integrators, output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r       <= {LOG2_R{1'b0}};
            u_r           <= {W{1'b0}};
            d_out_r       <= {OUT_WIDTH{1'b0}};
            d_out_valid_r <= 1'b0;
            underrun_r    <= 1'b0;
            for (int k = 0; k < M; k++) begin
                comb_z_r[k] <= {W{1'b0}};
                integ_r[k]  <= {W{1'b0}};
            end
        end else if (ce) begin
            phase_r <= phase_r + LOG2_R'(1'b1);
            if (slot_s) begin
                for (int k = 0; k < M; k++) begin
                    comb_z_r[k] <= comb_x_s[k];
                end
                u_r <= comb_out_s;
            end else begin
                u_r <= {W{1'b0}};
            end
            if (slot_s & ~hold_valid_r) begin
                underrun_r <= 1'b1;
            end
            // Every integrator reads pre-update values, giving one register of delay per stage
            integ_r[0] <= integ_r[0] + u_r;
            for (int k = 1; k < M; k++) begin
                integ_r[k] <= integ_r[k] + integ_r[k-1];
            end
            d_out_r       <= out_next_s;
            d_out_valid_r <= 1'b1;
        end else begin
            d_out_valid_r <= 1'b0;
        end
    end

    assign d_out       = d_out_r;
    assign d_out_valid = d_out_valid_r;
    assign underrun    = underrun_r;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator (M=3, R=4, 16-bit), plus a 12-bit-output instance that exercises wrap/clamp.
// The reference computes each output as a convolution of the zero-stuffed input with the CIC impulse response.
`timescale 1ns/1ps
module tb_cic_interpolator;
    localparam int M      = 3;
    localparam int LOG2_R = 2;
    localparam int R      = 4;
    localparam int IW     = 16;
    localparam int OW     = 16;
    localparam int OWN    = 12;
    localparam int W      = IW + M * LOG2_R;
    localparam int SH     = (M - 1) * LOG2_R;
    localparam int L      = M * (R - 1) + 1;
    localparam int HL     = M + 1 + L;

    localparam longint H_EXP   [L] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    localparam longint IMP_EXP [L] = '{4, 12, 24, 40, 48, 48, 40, 24, 12, 4};
    localparam longint DC_EXP  [6] = '{62, 187, 375, 625, 812, 937};

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic [IW-1:0]  d_in;
    logic           d_in_valid;
    logic           d_in_ready, d_out_valid, underrun;
    logic [OW-1:0]  d_out;
    logic           d_in_ready_n, d_out_valid_n, underrun_n;
    logic [OWN-1:0] d_out_n;

    int checks = 0;
    int errors = 0;

    // reference state
    longint h [L];
    longint xh [HL];
    logic   m_hv, m_underrun, m_dvalid;
    longint m_hold, m_dout, m_dout_n;
    int     m_phase;
    logic   live = 1'b0;
    logic   mv_slot, mv_ready, mv_pop;
    longint mv_x, mv_raw;

    cic_interpolator #(.M(M), .LOG2_R(LOG2_R), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst(rst), .ce(ce), .d_in(d_in), .d_in_valid(d_in_valid),
        .d_in_ready(d_in_ready), .d_out(d_out), .d_out_valid(d_out_valid), .underrun(underrun));

    cic_interpolator #(.M(M), .LOG2_R(LOG2_R), .IN_WIDTH(IW), .OUT_WIDTH(OWN)) dut_n (
        .clk(clk), .rst(rst), .ce(ce), .d_in(d_in), .d_in_valid(d_in_valid),
        .d_in_ready(d_in_ready_n), .d_out(d_out_n), .d_out_valid(d_out_valid_n), .underrun(underrun_n));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Impulse response of M cascaded length-R boxcars
    function automatic void build_h();
        longint t [L];
        int len;
        for (int i = 0; i < L; i++) h[i] = 0;
        h[0] = 1;
        len = 1;
        for (int s = 0; s < M; s++) begin
            for (int i = 0; i < L; i++) t[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) t[i+j] += h[i];
            len += R - 1;
            for (int i = 0; i < L; i++) h[i] = t[i];
        end
    endfunction

    // Wrap to W bits, divide by R^(M-1) (floor), then fit to ow bits
    function automatic longint to_out(input longint raw, input int ow);
        logic [W-1:0]        rw;
        logic signed [W-1:0] sv;
        longint s, lim;
        rw  = raw[W-1:0];
        sv  = $signed(rw) >>> SH;
        s   = sv;
        lim = 1;
        lim = lim << (ow - 1);
`ifdef CIC_INTERP_SAT_EN
        if (s > lim - 1) s = lim - 1;
        else if (s < -lim) s = -lim;
`else
        s = s % (2 * lim);
        if (s < 0) s += 2 * lim;
        if (s >= lim) s -= 2 * lim;
`endif
        return s;
    endfunction

    // Reference update at each active edge
    always @(posedge clk) begin
        if (rst) begin
            live = 1'b1;
            m_hv = 1'b0; m_hold = 0; m_phase = 0; m_underrun = 1'b0;
            m_dout = 0; m_dout_n = 0; m_dvalid = 1'b0;
            for (int i = 0; i < HL; i++) xh[i] = 0;
        end else if (live) begin
            mv_slot  = ce && (m_phase == 0);
            mv_pop   = mv_slot && m_hv;
            mv_ready = !m_hv || mv_pop;
            if (ce) begin
                mv_x = 0;
                if (mv_slot) begin
                    if (m_hv) mv_x = m_hold;
                    else m_underrun = 1'b1;
                end
                for (int i = HL - 1; i > 0; i--) xh[i] = xh[i-1];
                xh[0] = mv_x;
                mv_raw = 0;
                for (int k = 0; k < L; k++) mv_raw += h[k] * xh[M+1+k];
                m_dout   = to_out(mv_raw, OW);
                m_dout_n = to_out(mv_raw, OWN);
                m_dvalid = 1'b1;
                m_phase  = (m_phase + 1) % R;
            end else begin
                m_dvalid = 1'b0;
            end
            if (d_in_valid && mv_ready) begin
                m_hold = longint'($signed(d_in));
                m_hv   = 1'b1;
            end else if (mv_pop) begin
                m_hv = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the reference
    always @(negedge clk) begin
        if (live) begin
            chk("ready",      d_in_ready,       !m_hv || (ce && m_phase == 0));
            chk("dout",       $signed(d_out),   m_dout);
            chk("dvalid",     d_out_valid,      m_dvalid);
            chk("underrun",   underrun,         m_underrun);
            chk("ready_n",    d_in_ready_n,     !m_hv || (ce && m_phase == 0));
            chk("dout_n",     $signed(d_out_n), m_dout_n);
            chk("dvalid_n",   d_out_valid_n,    m_dvalid);
            chk("underrun_n", underrun_n,       m_underrun);
        end
    end

    task automatic cyc(input logic c, input logic v, input logic [IW-1:0] d);
        ce = c; d_in_valid = v; d_in = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic [IW-1:0] d);
        rst = 1'b1; ce = 1'b1; d_in_valid = 1'b1; d_in = d;
        @(posedge clk); #1;
        chk("rst_dout",     $signed(d_out), 0);
        chk("rst_dvalid",   d_out_valid, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready",    d_in_ready, 1);
        rst = 1'b0;
    endtask

    // Reset, preload one sample with ce low, then n ticks of constant input
    task automatic run_dc(input logic [IW-1:0] v, input int n);
        longint vs;
        vs = longint'($signed(v));
        do_reset(v);
        cyc(1'b0, 1'b1, v);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, v);
            chk("dc_ready", d_in_ready, ((i + 1) % R) == 0);
            if (i >= 10) chk("dc_settle", $signed(d_out), vs);
            if (vs == 1000 && i >= 4 && i < 10) chk("dc_ramp", $signed(d_out), DC_EXP[i-4]);
            if (vs > 0 && $signed(d_out) > vs) chk("dc_overshoot", $signed(d_out), vs);
        end
    endtask

    initial begin
        logic seen_hi, seen_lo;
        rst = 1'b1; ce = 1'b0; d_in_valid = 1'b0; d_in = 16'd0;
        build_h();
        for (int i = 0; i < L; i++) chk("h_coef", h[i], H_EXP[i]);

        // impulse
        do_reset(16'd0);
        cyc(1'b0, 1'b1, 16'd64);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 16'd0);
            chk("impulse", $signed(d_out), (i >= 4 && i < 4 + L) ? IMP_EXP[i-4] : 0);
            chk("imp_underrun", underrun, 0);
        end

        // DC, then again with a reset taken while streaming
        run_dc(16'd1000, 40);
        run_dc(16'd1000, 40);

        // starve one slot, then ce gating
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'd0);
        chk("underrun_set", underrun, 1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 16'd1000);
        chk("underrun_sticky", underrun, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 16'd1000);
            chk("gated_dvalid", d_out_valid, 0);
        end
        cyc(1'b1, 1'b1, 16'd1000);
        chk("ungated_dvalid", d_out_valid, 1);

        // out-of-range for the 12-bit instance
        run_dc(16'd3000, 24);
`ifdef CIC_INTERP_SAT_EN
        chk("narrow_pos", $signed(d_out_n), 2047);
`else
        chk("narrow_pos", $signed(d_out_n), -1096);
`endif
        run_dc(-16'sd3000, 24);
`ifdef CIC_INTERP_SAT_EN
        chk("narrow_neg", $signed(d_out_n), -2048);
`else
        chk("narrow_neg", $signed(d_out_n), 1096);
`endif

        // alternating full-scale steps every slot
        do_reset(16'h7fff);
        cyc(1'b0, 1'b1, 16'h7fff);
        seen_hi = 1'b0; seen_lo = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cyc(1'b1, 1'b1, ((i / R) % 2) ? 16'h7fff : 16'h8000);
            if ($signed(d_out_n) == 2047) seen_hi = 1'b1;
            if ($signed(d_out_n) == -2048) seen_lo = 1'b1;
        end
`ifdef CIC_INTERP_SAT_EN
        chk("sat_hi_seen", seen_hi, 1);
        chk("sat_lo_seen", seen_lo, 1);
`endif

        // randomized traffic, gating and occasional resets
        do_reset(16'd0);
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(299) == 0);
            ce         = ($urandom_range(3) != 0);
            d_in_valid = ($urandom_range(9) < 7);
            d_in       = ($urandom_range(1) == 0) ? 16'($urandom) : 16'($urandom_range(400)) - 16'd200;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
